// File: rtl/mult_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_div : 32x32 signed multiply (radix-2 Booth) and divide (restoring).
// Rev 1.0
// ---------------------------------------------------------------------------
module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [32:0] r_acc;
  logic [31:0] r_q;
  logic        r_qm1;
  logic [32:0] r_m;
  logic        r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_div_zero;

  logic        w_bz;
  logic        w_dz_fire;
  logic        w_last;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_sum;
  logic [32:0] w_rs;
  logic [32:0] w_diff;
  logic [32:0] w_acc_nxt;
  logic [31:0] w_q_nxt;
  logic        w_qm1_nxt;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_bz      = op && (b == 32'd0);
  assign w_dz_fire = (r_state == S_IDLE) && start && w_bz;
  assign w_last    = (r_cnt == 5'd31);
  assign w_abs_a   = a[31] ? (32'd0 - a) : a;
  assign w_abs_b   = b[31] ? (32'd0 - b) : b;

  // One iteration of either algorithm; r_acc/r_q/r_m are shared between them.
  always_comb begin
    w_sum     = r_acc;
    w_rs      = {r_acc[31:0], r_q[31]};
    w_diff    = w_rs - r_m;
    w_acc_nxt = r_acc;
    w_q_nxt   = r_q;
    w_qm1_nxt = r_qm1;
    if (!r_op) begin
      case ({r_q[0], r_qm1})
        2'b01:   w_sum = r_acc + r_m;
        2'b10:   w_sum = r_acc - r_m;
        default: w_sum = r_acc;
      endcase
      w_acc_nxt = {w_sum[32], w_sum[32:1]};
      w_q_nxt   = {w_sum[0], r_q[31:1]};
      w_qm1_nxt = r_q[0];
    end else begin
      w_acc_nxt = w_diff[32] ? w_rs : w_diff;
      w_q_nxt   = {r_q[30:0], ~w_diff[32]};
    end
  end

  always_comb begin
    if (!r_op) begin
      w_res_hi = w_acc_nxt[31:0];
      w_res_lo = w_q_nxt;
    end else begin
      w_res_hi = r_neg_r ? (32'd0 - w_acc_nxt[31:0]) : w_acc_nxt[31:0];
      w_res_lo = r_neg_q ? (32'd0 - w_q_nxt) : w_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_bz ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc      <= 33'd0;
      r_q        <= 32'd0;
      r_qm1      <= 1'b0;
      r_m        <= 33'd0;
      r_op       <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_cnt      <= 5'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_div_zero <= w_dz_fire;
      case (r_state)
        S_IDLE: begin
          if (start && !w_bz) begin
            r_op    <= op;
            r_acc   <= 33'd0;
            r_qm1   <= 1'b0;
            r_cnt   <= 5'd0;
            r_neg_q <= a[31] ^ b[31];
            r_neg_r <= a[31];
            if (!op) begin
              r_q <= b;
              r_m <= {a[31], a};
            end else begin
              r_q <= w_abs_a;
              r_m <= {1'b0, w_abs_b};
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= w_qm1_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_mult_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_div : directed self-checking bench for mult_div.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mult_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_op = 1'b0;
  logic [31:0] i_a = 32'd0;
  logic [31:0] i_b = 32'd0;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;
  logic        o_div_zero;

  int          r_checks = 0;
  int          r_errors = 0;
  logic [31:0] r_prev_hi = 32'd0;
  logic [31:0] r_prev_lo = 32'd0;

  mult_div u_dut (
    .clock    (clk),
    .reset    (rst),
    .start    (i_start),
    .op       (i_op),
    .a        (i_a),
    .b        (i_b),
    .hi       (o_hi),
    .lo       (o_lo),
    .busy     (o_busy),
    .done     (o_done),
    .div_zero (o_div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // exp_lat: edges after the start edge until done is seen (0 for divide-by-zero)
  task automatic run_op(input string tag, input logic op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat, input logic exp_dz,
                        input int inject_at);
    int n;
    int extra;
    @(negedge clk);
    i_op = op_v; i_a = a_v; i_b = b_v; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check({tag, "_busy_start"}, o_busy, 1);
    n = 0;
    while (!o_done && n < 40) begin
      if (n == inject_at) begin
        i_start = 1'b1; i_op = 1'b0; i_a = 32'h00000005; i_b = 32'h00000009;
      end else begin
        i_start = 1'b0;
      end
      if (n == 10) begin
        check({tag, "_hi_calc"}, o_hi, r_prev_hi);
        check({tag, "_lo_calc"}, o_lo, r_prev_lo);
        check({tag, "_done_calc"}, o_done, 0);
      end
      @(posedge clk); #1;
      n++;
    end
    i_start = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_hi"}, o_hi, exp_hi);
    check({tag, "_lo"}, o_lo, exp_lo);
    check({tag, "_dz"}, o_div_zero, exp_dz);
    check({tag, "_busy_done"}, o_busy, 1);
    @(posedge clk); #1;
    check({tag, "_done_end"}, o_done, 0);
    check({tag, "_busy_end"}, o_busy, 0);
    check({tag, "_dz_end"}, o_div_zero, 0);
    extra = 0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      if (o_done) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_hi_hold"}, o_hi, exp_hi);
    r_prev_hi = exp_hi;
    r_prev_lo = exp_lo;
  endtask

  initial begin
    int extra;
    #2 rst = 1'b1;
    #1;
    check("rst_hi", o_hi, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_dz", o_div_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run_op("mul_7x-3",  1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 32, 1'b0, -1);
    run_op("mul_maxpos", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 32, 1'b0, -1);
    run_op("mul_minneg", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32, 1'b0, -1);
    run_op("div_-7/2",  1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 32, 1'b0, -1);
    run_op("div_7/-2",  1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32, 1'b0, -1);
    run_op("div_100/7", 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       32, 1'b0, -1);
    run_op("div_-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,   32, 1'b0, -1);
    run_op("mul_setup", 1'b0, 32'h33333333, 32'h55555556, 32'h11111111, 32'h22222222, 32, 1'b0, -1);
    run_op("div_zero",  1'b1, 32'h12345678, 32'h00000000, 32'h11111111, 32'h22222222, 0, 1'b1, -1);
    run_op("div_ovf",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32, 1'b0, 4);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    i_op = 1'b0; i_a = 32'h00001234; i_b = 32'h00005678; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_hi", o_hi, 0);
    check("abort_lo", o_lo, 0);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      if (o_done) extra++;
    end
    check("abort_no_done", extra, 0);
    r_prev_hi = 32'd0;
    r_prev_lo = 32'd0;
    run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 32, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and 64-bit result.
REQ-002 The block SHALL have the following ports:
- clock     in   1   single system clock; all state changes on rising edge.
- reset     in   1   asynchronous, active-high.
- start     in   1   request strobe, sampled only in IDLE.
- op        in   1   0 = signed multiply, 1 = signed divide.
- a         in   32  multiplicand / dividend (two's complement).
- b         in   32  multiplier / divisor (two's complement).
- hi        out  32  product[63:32] or remainder.
- lo        out  32  product[31:0] or quotient.
- busy      out  1   operation in progress (CALC or DONE).
- done      out  1   one-cycle completion pulse.
- div_zero  out  1   divide-by-zero flag, valid only with done.
REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-005 IDLE SHALL move to CALC on the edge k where start=1 and op/b is not a divide by zero.
- a, b and op are captured on that edge.
- The iteration counter is cleared on that edge.
REQ-006 CALC SHALL perform one iteration per edge for edges k+1 to k+32.
- Multiply uses radix-2 Booth.
- Divide uses restoring division on magnitudes.
REQ-007 On edge k+32 the FSM SHALL go CALC->DONE and load hi/lo with the final result.
REQ-008 done SHALL be 1 only in DONE, for exactly one cycle (edges k+32 to k+33); at edge k+33 the FSM SHALL return to IDLE.
REQ-009 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-010 start SHALL be ignored while busy=1; captured operands and the result are unaffected.
REQ-011 Multiply SHALL produce {hi,lo} = exact signed 64-bit product of a and b.
REQ-012 Divide SHALL follow MIPS rules: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
REQ-013 Divide 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no flag.
REQ-014 A divide with b=0 sampled at edge k SHALL go IDLE->DONE directly.
- done=1 and div_zero=1 during cycle k+1.
- hi and lo unchanged.
REQ-015 div_zero SHALL be 0 whenever done=0 and after every non-zero-divisor completion.
REQ-016 hi and lo SHALL hold their last completed values until the next successful completion.
- They SHALL NOT change during CALC.
REQ-017 A start sampled in the same edge that DONE->IDLE occurs SHALL be ignored; a new start is accepted from IDLE only.

Reset
REQ-018 Asserting reset SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0 and counter=0, regardless of clock.
REQ-019 Reset during CALC or DONE SHALL abort the operation.
- No done pulse is produced for it.
- hi and lo read 0.
REQ-020 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-021 Multiply: op=0, a=7, b=0xFFFFFFFD (-3), start at edge k -> done=1 only in cycle k+32..k+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy=1 from k to k+33.
REQ-022 Multiply: a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001; then a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-023 Divide: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001; div_zero=0 in both cases.
REQ-024 Divide by zero: prior hi/lo = 0x11111111/0x22222222, op=1, b=0 -> done=1 and div_zero=1 one cycle after start, hi/lo unchanged, busy back to 0 the following cycle.
REQ-025 Overflow divide 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; second start pulsed at k+5 during CALC -> ignored, exactly one done pulse.
REQ-026 Reset asserted mid-cycle at k+10 of a multiply -> outputs 0 immediately with no edge, no done pulse; new multiply 3*4 after release -> hi=0, lo=12 after 32 further edges.
